// File: rtl/dmem_arbiter.sv
// Purpose : round-robin two-master arbiter in front of the single-port data memory, with bounded burst lock.
// Latency : grant is combinational in cycle t; the registered response (rvalid/rdata/err) appears in cycle t+1.
// Backpres: a requester that is not granted simply holds req until its gnt; responses cannot be stalled.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   mK_req/we/lock/addr/wdata   master K request (K = 0 CPU, 1 loader/debug)
//   mK_gnt                      access accepted this cycle (combinational)
//   mK_rvalid/rdata/err         registered response, one cycle after mK_gnt
//   mem_we/addr/wdata, mem_rdata  single-port memory interface (read data combinational)
module dmem_arbiter #(
    parameter int n        = 32,
    parameter int DEPTH    = 64,
    parameter int MAX_LOCK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_req,
    input  logic         m0_we,
    input  logic         m0_lock,
    input  logic [n-1:0] m0_addr,
    input  logic [n-1:0] m0_wdata,
    output logic         m0_gnt,
    output logic         m0_rvalid,
    output logic [n-1:0] m0_rdata,
    output logic         m0_err,
    input  logic         m1_req,
    input  logic         m1_we,
    input  logic         m1_lock,
    input  logic [n-1:0] m1_addr,
    input  logic [n-1:0] m1_wdata,
    output logic         m1_gnt,
    output logic         m1_rvalid,
    output logic [n-1:0] m1_rdata,
    output logic         m1_err,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);

    localparam int              CW      = $clog2(MAX_LOCK + 1);
    localparam logic [n-3:0]    DEPTH_W = (n-2)'(DEPTH);
    localparam logic [CW-1:0]   MAX_W   = CW'(MAX_LOCK);

    logic          last;        // last granted master
    logic          lock_act;
    logic          lock_own;
    logic [CW-1:0] lock_cnt;

    logic          rsp_v;
    logic          rsp_id;
    logic          rsp_err;
    logic [n-1:0]  rsp_data;

    logic          g0, g1, gnt_any;
    logic          sel_we, sel_lock, bad, keep_lock, owner_req;
    logic [n-1:0]  sel_addr, sel_wdata;
    logic [CW-1:0] cnt_next;

    // Grant selection: a held lock excludes the other master entirely.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (lock_act) begin
            g0 = ~lock_own & m0_req;
            g1 =  lock_own & m1_req;
        end else if (m0_req & m1_req) begin
            g0 =  last;
            g1 = ~last;
        end else begin
            g0 = m0_req;
            g1 = m1_req;
        end
    end

    assign gnt_any   = g0 | g1;
    assign m0_gnt    = g0;
    assign m1_gnt    = g1;

    assign sel_addr  = g1 ? m1_addr  : m0_addr;
    assign sel_wdata = g1 ? m1_wdata : m0_wdata;
    assign sel_we    = g1 ? m1_we    : m0_we;
    assign sel_lock  = g1 ? m1_lock  : m0_lock;

    assign bad = (sel_addr[1:0] != 2'b00) | (sel_addr[n-1:2] >= DEPTH_W);

    // Reset gates the write strobe so a request coinciding with rst never reaches the array.
    assign mem_we    = gnt_any & sel_we & ~bad & ~rst;
    assign mem_addr  = gnt_any ? sel_addr  : '0;
    assign mem_wdata = gnt_any ? sel_wdata : '0;

    // Count of consecutive locked grants including the one happening now.
    assign cnt_next  = lock_act ? (lock_cnt + CW'(1)) : CW'(1);
    assign keep_lock = sel_lock & (cnt_next < MAX_W);
    assign owner_req = lock_own ? m1_req : m0_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 1'b1;
            lock_act <= 1'b0;
            lock_own <= 1'b0;
            lock_cnt <= '0;
            rsp_v    <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_v <= gnt_any;
            if (gnt_any) begin
                rsp_id   <= g1;
                rsp_err  <= bad;
                rsp_data <= (~sel_we & ~bad) ? mem_rdata : '0;
                last     <= g1;
                if (keep_lock) begin
                    lock_act <= 1'b1;
                    lock_own <= g1;
                    lock_cnt <= cnt_next;
                end else begin
                    lock_act <= 1'b0;
                    lock_cnt <= '0;
                end
            end else if (lock_act & ~owner_req) begin
                // Owner went idle: drop the lock; the other master is served from next cycle.
                lock_act <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

    assign m0_rvalid = rsp_v & ~rsp_id;
    assign m1_rvalid = rsp_v &  rsp_id;
    assign m0_rdata  = m0_rvalid ? rsp_data : '0;
    assign m1_rdata  = m1_rvalid ? rsp_data : '0;
    assign m0_err    = m0_rvalid & rsp_err;
    assign m1_err    = m1_rvalid & rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word behavioural memory.
// Inputs change 1 time unit after posedge; combinational outputs are sampled 1 unit later,
// registered outputs right after the posedge settles.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int errors  = 0;

    logic        load;
    logic [31:0] ram [64];

    always #5 clk = ~clk;

    dmem_arbiter #(.n(32), .DEPTH(64), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'hA500_0000 | i;
            ram[1] <= 32'h1111_1111;
            ram[2] <= 32'hDEAD_BEEF;
            ram[3] <= 32'hCAFE_F00D;
        end else if (mem_we) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = ram[mem_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        rst = 1'b1; load = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0; m0_addr = 32'h8; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;

        // Reset with a write request pending: nothing may reach the memory.
        tick();
        load = 1'b0;
        #1;
        check("rst_mem_we", mem_we, 0);
        tick();
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_err", m1_err, 0);
        check("rst_ram2", ram[2], 32'hDEAD_BEEF);
        rst = 1'b0; m0_req = 1'b0; m0_we = 1'b0;

        // Single m0 read of word 2.
        m0_req = 1'b1; m0_addr = 32'h8;
        #1;
        check("rd0_m0_gnt", m0_gnt, 1);
        check("rd0_m1_gnt", m1_gnt, 0);
        check("rd0_mem_addr", mem_addr, 32'h8);
        check("rd0_mem_we", mem_we, 0);
        tick();
        m0_req = 1'b0;
        check("rd0_m0_rvalid", m0_rvalid, 1);
        check("rd0_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rd0_m0_err", m0_err, 0);
        check("rd0_m1_rvalid", m1_rvalid, 0);
        check("rd0_m1_rdata", m1_rdata, 0);
        check("rd0_m1_err", m1_err, 0);

        // Single m1 read of word 3; leaves last = m1 so the next tie goes to m0.
        m1_req = 1'b1; m1_addr = 32'hC;
        #1;
        check("rd1_m1_gnt", m1_gnt, 1);
        tick();
        m1_req = 1'b0;
        check("rd1_m1_rvalid", m1_rvalid, 1);
        check("rd1_m1_rdata", m1_rdata, 32'hCAFE_F00D);
        check("rd1_m0_rvalid", m0_rvalid, 0);

        // Both request continuously: m0, m1, m0, m1; responses follow one cycle later.
        m0_req = 1'b1; m0_addr = 32'h8;
        m1_req = 1'b1; m1_addr = 32'hC;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                exp0 = ((i - 1) % 2 == 0);
                check("rr_m0_rvalid", m0_rvalid, exp0);
                check("rr_m1_rvalid", m1_rvalid, !exp0);
                check("rr_m0_rdata", m0_rdata, exp0 ? 32'hDEAD_BEEF : 32'h0);
                check("rr_m1_rdata", m1_rdata, exp0 ? 32'h0 : 32'hCAFE_F00D);
            end
            if (i == 4) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            #1;
            if (i < 4) begin
                check("rr_m0_gnt", m0_gnt, (i % 2 == 0));
                check("rr_m1_gnt", m1_gnt, (i % 2 == 1));
            end
            tick();
        end

        // m0 alone once so last = m0, then m1 locks against a requesting m0.
        m0_req = 1'b1;
        #1;
        check("pre_lock_m0_gnt", m0_gnt, 1);
        tick();
        m1_req = 1'b1; m1_lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("lock_m1_gnt", m1_gnt, (i < 4));
            check("lock_m0_gnt", m0_gnt, (i == 4));
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;

        // Lock owner goes idle: one dead cycle for m0, then m0 is served.
        m1_req = 1'b1; m1_lock = 1'b1;
        #1;
        check("idle_m1_gnt", m1_gnt, 1);
        tick();
        m1_req = 1'b0; m1_lock = 1'b0; m0_req = 1'b1;
        #1;
        check("idle_dead_m0_gnt", m0_gnt, 0);
        check("idle_dead_m1_gnt", m1_gnt, 0);
        tick();
        #1;
        check("idle_after_m0_gnt", m0_gnt, 1);
        tick();
        m0_req = 1'b0;

        // m0 writes word 4, m1 reads it back on the very next grant.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1234_5678;
        #1;
        check("wr_m0_gnt", m0_gnt, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 32'h10);
        check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        tick();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
        check("wr_m0_rvalid", m0_rvalid, 1);
        check("wr_m0_rdata", m0_rdata, 0);
        check("wr_m0_err", m0_err, 0);
        #1;
        check("rb_m1_gnt", m1_gnt, 1);
        tick();
        m1_req = 1'b0;
        check("rb_m1_rvalid", m1_rvalid, 1);
        check("rb_m1_rdata", m1_rdata, 32'h1234_5678);
        check("rb_m1_err", m1_err, 0);
        check("rb_ram4", ram[4], 32'h1234_5678);

        // Misaligned write from m0, out-of-range read (word 64) from m1.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h6; m0_wdata = 32'hBAD0_BAD0;
        #1;
        check("mis_m0_gnt", m0_gnt, 1);
        check("mis_mem_we", mem_we, 0);
        tick();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100;
        check("mis_m0_rvalid", m0_rvalid, 1);
        check("mis_m0_err", m0_err, 1);
        check("mis_m0_rdata", m0_rdata, 0);
        #1;
        check("oor_m1_gnt", m1_gnt, 1);
        check("oor_mem_we", mem_we, 0);
        tick();
        m1_req = 1'b0;
        check("oor_m1_rvalid", m1_rvalid, 1);
        check("oor_m1_err", m1_err, 1);
        check("oor_m1_rdata", m1_rdata, 0);
        check("mis_ram1", ram[1], 32'h1111_1111);

        // m1 takes a lock, then rst arrives while m1 (still owner) attempts a write.
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'hC;
        #1;
        check("pre_rst_m1_gnt", m1_gnt, 1);
        tick();
        rst = 1'b1;
        m1_lock = 1'b0; m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
        #1;
        check("rst2_mem_we", mem_we, 0);
        tick();
        rst = 1'b0;
        m1_we = 1'b0; m1_addr = 32'hC;
        check("rst2_m0_rvalid", m0_rvalid, 0);
        check("rst2_m1_rvalid", m1_rvalid, 0);
        #1;
        check("rst2_tie_m0_gnt", m0_gnt, 1);
        check("rst2_tie_m1_gnt", m1_gnt, 0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        check("rst2_m0_rvalid_after", m0_rvalid, 1);
        check("rst2_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rst2_ram2", ram[2], 32'hDEAD_BEEF);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 64-word data memory.
- Shares the memory between master 0 (CPU load/store stage) and master 1 (program/data loader or debug port).
- Grants at most one access per cycle, round-robin, with an optional bounded lock for back-to-back bursts.
- Registers a one-cycle-later response carrying read data, write ack or error.
- Drives the memory's write-enable, address and write-data inputs; consumes its combinational read data.

Parameters:
- n, 32, data/address width.
- DEPTH, 64, memory depth in words; the word index is addr[n-1:2].
- MAX_LOCK, 4, maximum consecutive grants a locking master may hold (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- m0_req / m1_req  input  1  access request.
- m0_we / m1_we  input  1  1 = write, 0 = read.
- m0_lock / m1_lock  input  1  request to retain ownership after this access.
- m0_addr / m1_addr  input  n  byte address.
- m0_wdata / m1_wdata  input  n  write data.
- m0_gnt / m1_gnt  output  1  combinational; access accepted this cycle.
- m0_rvalid / m1_rvalid  output  1  registered response strobe, one cycle after the grant.
- m0_rdata / m1_rdata  output  n  registered read data; 0 for writes and errors.
- m0_err / m1_err  output  1  registered, qualifies rvalid; misaligned or out-of-range access.
- mem_we  output  1  to memory write_enable.
- mem_addr  output  n  to memory addr.
- mem_wdata  output  n  to memory writedata.
- mem_rdata  input  n  from memory readdata (combinational).

Behaviour:
- State registers:
  - last: last granted master.
  - lock_act, lock_own, lock_cnt[$clog2(MAX_LOCK+1)-1:0].
  - rsp_v, rsp_id, rsp_data, rsp_err.
- Reset:
  - last=1, so m0 wins the first tie.
  - lock_act=0, lock_cnt=0.
  - All rvalid/err = 0, all rdata = 0.
  - Any pending response is discarded.
- Grant selection (combinational, evaluated each cycle):
  - If lock_act: only lock_own may be granted, and only if its req=1. The other master waits even if it is requesting.
  - Else if only one master requests: grant it.
  - Else if both request: grant the master != last.
  - At most one gnt is high per cycle. No req means no gnt.
- Memory drive when master k is granted:
  - mem_addr = mk_addr.
  - mem_wdata = mk_wdata.
  - mem_we = mk_we & ~bad.
  - bad = (mk_addr[1:0] != 0) | (mk_addr[n-1:2] >= DEPTH).
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Response, registered on the posedge that ends the grant cycle:
  - rsp_v=1, rsp_id=k.
  - rsp_err=bad.
  - rsp_data = (~mk_we & ~bad) ? mem_rdata : 0.
  - mk_rvalid = rsp_v & (rsp_id==k); rdata and err are routed likewise; the other master sees 0.
  - Latency: gnt in cycle t, rvalid in cycle t+1.
  - Pipelined: a new grant in t+1 is legal, giving back-to-back rvalid.
- last updates to k on every grant.
- Lock counter, on a grant to k:
  - If mk_lock=1 and (lock_act ? lock_cnt+1 : 1) < MAX_LOCK: lock_act=1, lock_own=k, lock_cnt increments (starts at 1 on the first locked grant).
  - Otherwise (lock=0, or count reaches MAX_LOCK): lock_act=0, lock_cnt=0. The other master wins the next tie via last.
- Lock release while the owner is idle: if lock_act and the owner's req=0 in a cycle, release the lock (lock_act=0, lock_cnt=0) at that edge. No grant is given to the other master in that cycle; it is granted from the next cycle.
- MAX_LOCK=1 disables locking.
- Write followed by read of the same address in consecutive grants must return the new data, since the memory writes on the grant posedge.
- Simultaneous rst and req: rst wins; no grant is accepted as state; the gnt output in that cycle is don't-care; no memory write occurs (mem_we forced 0 while rst=1).

Test Plan:
- Reset, then m0 read of addr 0x8 (RAM[2]=0xDEADBEEF preloaded) → m0_gnt in cycle 0; m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_err=0 in cycle 1; m1 outputs all 0.
- Both request continuously, no lock → grants m0,m1,m0,m1 on consecutive cycles; rvalid alternates the same way one cycle later.
- m1 locks with req held and m0 requesting, MAX_LOCK=4 → m1 granted 4 consecutive cycles, then m0 granted on the 5th.
- m0 writes 0x12345678 to 0x10, then m1 reads 0x10 next cycle → m1_rdata=0x12345678.
- m0 write to 0x6 (misaligned) and m1 read of 0x100 (word 64, out of range) → m0_err=1 and m1_err=1 on their response cycles, mem_we=0, rdata=0, RAM unchanged.
- rst asserted in the cycle after a grant → rvalid stays 0, lock cleared; the next tie grants m0.
